instruction_fetch_unit: RTL and testbench
=========================================

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, fetch address loaded on reset.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: imem_req  output  1  instruction-memory read request.
REQ-005 Port: imem_addr  output  32  word-aligned fetch address.
REQ-006 Port: imem_gnt  input  1  request accepted this cycle when imem_req=1.
REQ-007 Port: imem_rvalid  input  1  read data valid; arrives >=1 cycle after grant.
REQ-008 Port: imem_rdata  input  32  instruction word.
REQ-009 Port: redirect_valid  input  1  branch/jump redirect strobe.
REQ-010 Port: redirect_pc  input  32  redirect target.
REQ-011 Port: stall  input  1  decode cannot accept instr_out this cycle.
REQ-012 Port: instr_valid  output  1  instr_out/pc_out hold a valid instruction for decode and the immediate generator.
REQ-013 Port: instr_out  output  32  registered instruction word.
REQ-014 Port: pc_out  output  32  address instr_out was fetched from.

Function
REQ-015 The block SHALL implement FSM states REQ (may issue) and WAIT (granted, awaiting rvalid), plus a one-bit kill flag; at most one request outstanding.
REQ-016 The block SHALL hold internal pc; imem_addr = pc with bits [1:0] always 0.
REQ-017 In REQ, the block SHALL raise imem_req when (!instr_valid || !stall); once raised and not granted, imem_req and imem_addr SHALL stay constant until imem_gnt, regardless of stall or redirect.
REQ-018 On imem_req && imem_gnt, the block SHALL latch the fetch address and move to WAIT; imem_req SHALL be 0 throughout WAIT.
REQ-019 In WAIT, on imem_rvalid with kill=0: instr_out<=imem_rdata, pc_out<=latched address, instr_valid<=1, pc<=pc+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), state<=REQ.
REQ-020 In WAIT, on imem_rvalid with kill=1: data dropped, kill<=0, instr_valid unchanged, state<=REQ.
REQ-021 Consumption: instr_valid SHALL clear on an edge where instr_valid && !stall, unless new data is captured on that edge.
REQ-022 While stall=1 and instr_valid=1, instr_out, pc_out, instr_valid SHALL be unchanged.
REQ-023 Redirect (priority over stall and capture): on redirect_valid, pc<={redirect_pc[31:2],2'b00} and instr_valid<=0.
REQ-024 Redirect while in WAIT without rvalid, or in the same cycle as a grant, or while imem_req is held ungranted SHALL set kill=1 so the resulting response is dropped per REQ-020.
REQ-025 Redirect in the same cycle as imem_rvalid SHALL drop that data and not set kill.
REQ-026 Redirect in REQ with imem_req=0 SHALL only update pc; next request uses the new pc.
REQ-027 A response SHALL never be lost: rvalid in WAIT always finds the output slot empty by REQ-017.

Reset
REQ-028 While rst=1: pc=RESET_PC, state=REQ, kill=0, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr_out=32'h0000_0013 (NOP), pc_out=0.
REQ-029 Reset mid-transaction SHALL abandon the outstanding request; rvalid received before the first post-reset grant SHALL be ignored.
REQ-030 First imem_req SHALL assert in the first cycle after rst deasserts.

Verification
REQ-031 Reset release, gnt same cycle, rvalid next cycle with 32'h00500093, stall=0 -> imem_addr 0, then instr_valid=1, instr_out=32'h00500093, pc_out=0, next imem_addr=4.
REQ-032 gnt held low 3 cycles with stall toggling -> imem_req=1 and imem_addr constant all 3 cycles.
REQ-033 stall=1 for 4 cycles with instr_valid=1 -> outputs frozen, imem_req=0; stall drop -> imem_req rises same cycle.
REQ-034 Redirect to 32'h0000_0103 in WAIT, rvalid two cycles later -> returned data dropped, instr_valid=0, next imem_addr=32'h0000_0100.
REQ-035 pc=32'hFFFF_FFFC, fetch completes -> pc_out=32'hFFFF_FFFC, next imem_addr=0.
REQ-036 Redirect and imem_rvalid same cycle -> data dropped, kill stays 0, next imem_addr=redirect target.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Single-outstanding instruction fetch unit: issues word reads to instruction memory
// and presents one registered instruction to decode, with redirect and kill handling.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {S_REQ, S_WAIT} state_t;

  state_t      state_reg;
  logic        kill_reg;
  logic        pending_reg;
  logic [31:0] pc_reg;
  logic [31:0] fetch_addr_reg;
  logic        instr_valid_reg;
  logic [31:0] instr_out_reg;
  logic [31:0] pc_out_reg;
  logic [31:0] addr_sel;

  // An ungranted request keeps presenting its original address, even if pc moved
  assign addr_sel  = pending_reg ? fetch_addr_reg : pc_reg;
  assign imem_addr = {addr_sel[31:2], 2'b00};
  assign imem_req  = !rst && (state_reg == S_REQ) &&
                     (pending_reg || !instr_valid_reg || !stall);

  assign instr_valid = instr_valid_reg;
  assign instr_out   = instr_out_reg;
  assign pc_out      = pc_out_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= S_REQ;
      kill_reg        <= 1'b0;
      pending_reg     <= 1'b0;
      pc_reg          <= {RESET_PC[31:2], 2'b00};
      fetch_addr_reg  <= {RESET_PC[31:2], 2'b00};
      instr_valid_reg <= 1'b0;
      instr_out_reg   <= NOP;
      pc_out_reg      <= 32'h0000_0000;
    end else begin
      if (imem_req)
        fetch_addr_reg <= imem_addr;
      pending_reg <= imem_req && !imem_gnt;

      if (instr_valid_reg && !stall)
        instr_valid_reg <= 1'b0;

      case (state_reg)
        S_REQ: begin
          if (imem_req && imem_gnt)
            state_reg <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            state_reg <= S_REQ;
            kill_reg  <= 1'b0;
            if (!kill_reg && !redirect_valid) begin
              instr_out_reg   <= imem_rdata;
              pc_out_reg      <= fetch_addr_reg;
              instr_valid_reg <= 1'b1;
              pc_reg          <= pc_reg + 32'd4;
            end
          end
        end
        default: state_reg <= S_REQ;
      endcase

      // Redirect wins over stall and capture; any in-flight or held request is killed
      if (redirect_valid) begin
        pc_reg          <= {redirect_pc[31:2], 2'b00};
        instr_valid_reg <= 1'b0;
        if (imem_req || (state_reg == S_WAIT && !imem_rvalid))
          kill_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed self-checking bench for instruction_fetch_unit.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [31:0] pc_out;

  int checks = 0;
  int errors = 0;

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall(stall),
    .instr_valid(instr_valid), .instr_out(instr_out), .pc_out(pc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs change and outputs are sampled 1ns later
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
    redirect_valid = 0; redirect_pc = 0; stall = 0;
    cyc(); cyc();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 00000000", imem_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", instr_valid); end
    checks++; if (instr_out !== 32'h0000_0013) begin errors++; $display("FAIL reset_instr got %h exp 00000013", instr_out); end
    checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc_out got %h exp 00000000", pc_out); end
    $display("test_reset done");
  endtask

  task automatic test_basic_fetch();
    rst = 1'b0; imem_gnt = 1'b1; #1;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req got %b exp 1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL first_addr got %h exp 00000000", imem_addr); end
    cyc();
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h0050_0093; #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL wait_req got %b exp 0", imem_req); end
    cyc();
    imem_rvalid = 0; #1;
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", instr_valid); end
    checks++; if (instr_out !== 32'h0050_0093) begin errors++; $display("FAIL basic_instr got %h exp 00500093", instr_out); end
    checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL basic_pc_out got %h exp 00000000", pc_out); end
    checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL basic_next_addr got %h exp 00000004", imem_addr); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL basic_next_req got %b exp 1", imem_req); end
    $display("test_basic_fetch done");
  endtask

  task automatic test_gnt_hold();
    for (int i = 0; i < 3; i++) begin
      stall = i[0]; #1;
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL hold_req[%0d] got %b exp 1", i, imem_req); end
      checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL hold_addr[%0d] got %h exp 00000004", i, imem_addr); end
      cyc();
    end
    stall = 0; imem_gnt = 1; cyc();
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h1111_1111; cyc();
    imem_rvalid = 0; #1;
    checks++; if (pc_out !== 32'h4) begin errors++; $display("FAIL hold_pc_out got %h exp 00000004", pc_out); end
    $display("test_gnt_hold done");
  endtask

  task automatic test_stall();
    stall = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req[%0d] got %b exp 0", i, imem_req); end
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got %b exp 1", i, instr_valid); end
      checks++; if (instr_out !== 32'h1111_1111) begin errors++; $display("FAIL stall_instr[%0d] got %h exp 11111111", i, instr_out); end
      checks++; if (pc_out !== 32'h4) begin errors++; $display("FAIL stall_pc_out[%0d] got %h exp 00000004", i, pc_out); end
      cyc();
    end
    stall = 0; #1;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL unstall_req got %b exp 1", imem_req); end
    checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL unstall_addr got %h exp 00000008", imem_addr); end
    imem_gnt = 1; cyc();
    imem_gnt = 0;
    $display("test_stall done");
  endtask

  task automatic test_redirect_wait();
    redirect_valid = 1; redirect_pc = 32'h0000_0103; cyc();
    redirect_valid = 0; cyc();
    imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF; cyc();
    imem_rvalid = 0; #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_valid got %b exp 0", instr_valid); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL redir_req got %b exp 1", imem_req); end
    checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL redir_addr got %h exp 00000100", imem_addr); end
    imem_gnt = 1; cyc();
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h2222_2222; cyc();
    imem_rvalid = 0; #1;
    checks++; if (instr_out !== 32'h2222_2222) begin errors++; $display("FAIL redir_instr got %h exp 22222222", instr_out); end
    checks++; if (pc_out !== 32'h100) begin errors++; $display("FAIL redir_pc_out got %h exp 00000100", pc_out); end
    $display("test_redirect_wait done");
  endtask

  task automatic test_redirect_rvalid();
    imem_gnt = 1; cyc();
    imem_gnt = 0; redirect_valid = 1; redirect_pc = 32'h0000_0200;
    imem_rvalid = 1; imem_rdata = 32'h3333_3333; cyc();
    redirect_valid = 0; imem_rvalid = 0; #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL same_valid got %b exp 0", instr_valid); end
    checks++; if (imem_addr !== 32'h200) begin errors++; $display("FAIL same_addr got %h exp 00000200", imem_addr); end
    imem_gnt = 1; cyc();
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h4444_4444; cyc();
    imem_rvalid = 0; #1;
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL same_nokill_valid got %b exp 1", instr_valid); end
    checks++; if (instr_out !== 32'h4444_4444) begin errors++; $display("FAIL same_nokill_instr got %h exp 44444444", instr_out); end
    checks++; if (pc_out !== 32'h200) begin errors++; $display("FAIL same_nokill_pc_out got %h exp 00000200", pc_out); end
    $display("test_redirect_rvalid done");
  endtask

  task automatic test_wrap();
    redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC; #1;
    checks++; if (imem_addr !== 32'h204) begin errors++; $display("FAIL held_addr_redir got %h exp 00000204", imem_addr); end
    cyc();
    redirect_valid = 0; #1;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL held_req_after got %b exp 1", imem_req); end
    checks++; if (imem_addr !== 32'h204) begin errors++; $display("FAIL held_addr_after got %h exp 00000204", imem_addr); end
    imem_gnt = 1; cyc();
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h5555_5555; cyc();
    imem_rvalid = 0; #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL held_kill_valid got %b exp 0", instr_valid); end
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr got %h exp fffffffc", imem_addr); end
    imem_gnt = 1; cyc();
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h6666_6666; cyc();
    imem_rvalid = 0; #1;
    checks++; if (instr_out !== 32'h6666_6666) begin errors++; $display("FAIL wrap_instr got %h exp 66666666", instr_out); end
    checks++; if (pc_out !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc_out got %h exp fffffffc", pc_out); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_next_addr got %h exp 00000000", imem_addr); end
    $display("test_wrap done");
  endtask

  task automatic test_reset_mid();
    imem_gnt = 1; cyc();
    imem_gnt = 0; rst = 1; #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL async_valid got %b exp 0", instr_valid); end
    checks++; if (instr_out !== 32'h0000_0013) begin errors++; $display("FAIL async_instr got %h exp 00000013", instr_out); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL async_req got %b exp 0", imem_req); end
    cyc();
    rst = 0; imem_rvalid = 1; imem_rdata = 32'h7777_7777; #1;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL post_reset_req got %b exp 1", imem_req); end
    cyc();
    imem_rvalid = 0; #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL stale_rvalid_valid got %b exp 0", instr_valid); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL stale_rvalid_addr got %h exp 00000000", imem_addr); end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_gnt_hold();
    test_stall();
    test_redirect_wait();
    test_redirect_rvalid();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
